// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter and the planned receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  // Serial bits in one frame: start + data + optional parity + stop.
  function automatic int unsigned frame_bits(input int unsigned dw,
                                             input int unsigned par,
                                             input int unsigned stop);
    return 1 + dw + ((par != PAR_NONE) ? 1 : 0) + stop;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled, flags the last cycle.
module uart_baud_counter #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic bit_end
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= bit_end ? '0 : r_cnt + CNT_W'(1);
    end
  end

  // With a single clock per bit the counter never leaves 0, so this is constant 1.
  assign bit_end = (r_cnt == CNT_MAX);

endmodule

// File: rtl/stream_uart_tx.sv
// Valid/ready word stream to UART serial line: start, data LSB-first, optional parity, stop bits.
module stream_uart_tx #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  tx,
  output logic                  busy
);
  import uart_pkg::*;

  localparam int unsigned IDX_W = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);
  localparam bit HAS_PARITY = (PARITY == PAR_EVEN) || (PARITY == PAR_ODD);

  tx_state_t             r_state;
  tx_state_t             w_state_nxt;
  logic [DATA_WIDTH-1:0] r_shreg;
  logic [DATA_WIDTH-1:0] w_shreg_nxt;
  logic [IDX_W-1:0]      r_bit_idx;
  logic [IDX_W-1:0]      w_bit_idx_nxt;
  logic                  r_stop_idx;
  logic                  w_stop_idx_nxt;
  logic                  r_par;
  logic                  w_par_nxt;
  logic                  r_tx;
  logic                  w_tx_nxt;
  logic                  r_busy;
  logic                  w_bit_end;
  logic                  w_baud_en;
  logic                  w_ready;
  logic                  w_accept;

  assign w_baud_en = (r_state != IDLE);

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .clear  (w_accept),
    .en     (w_baud_en),
    .bit_end(w_bit_end)
  );

  // Ready in IDLE, and in the final cycle of the last stop bit for gapless frames.
  assign w_ready  = (r_state == IDLE) ||
                    ((r_state == STOP) && (r_stop_idx == LAST_STOP) && w_bit_end);
  assign w_accept = in_valid && w_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_shreg_nxt    = r_shreg;
    w_bit_idx_nxt  = r_bit_idx;
    w_stop_idx_nxt = r_stop_idx;
    w_par_nxt      = r_par;
    w_tx_nxt       = 1'b1;

    if (w_accept) begin
      w_shreg_nxt    = in_data;
      w_par_nxt      = (PARITY == PAR_EVEN) ? (^in_data) : (~^in_data);
      w_bit_idx_nxt  = '0;
      w_stop_idx_nxt = 1'b0;
    end

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_shreg_nxt = r_shreg >> 1;
          if (r_bit_idx == LAST_IDX) begin
            w_bit_idx_nxt  = '0;
            w_stop_idx_nxt = 1'b0;
            w_state_nxt    = HAS_PARITY ? uart_pkg::PARITY : STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + IDX_W'(1);
          end
        end
      end
      uart_pkg::PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = STOP;
        end
      end
      STOP: begin
        if (w_bit_end) begin
          if (r_stop_idx == LAST_STOP) begin
            w_state_nxt = w_accept ? START : IDLE;
          end else begin
            w_stop_idx_nxt = r_stop_idx + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // Line level for the upcoming cycle, so tx comes straight from a flop.
    case (w_state_nxt)
      START:            w_tx_nxt = 1'b0;
      DATA:             w_tx_nxt = w_shreg_nxt[0];
      uart_pkg::PARITY: w_tx_nxt = w_par_nxt;
      default:          w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_shreg    <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_par      <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shreg    <= w_shreg_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_stop_idx <= w_stop_idx_nxt;
      r_par      <= w_par_nxt;
      r_tx       <= w_tx_nxt;
      r_busy     <= (w_state_nxt != IDLE);
    end
  end

  assign in_ready = w_ready;
  assign tx       = r_tx;
  assign busy     = r_busy;

endmodule

// File: tb/tb_stream_uart_tx.sv
// Bench for stream_uart_tx: four configurations checked against a bit-position frame model.
module tb_stream_uart_tx;

  logic       clk;
  logic       reset;
  logic [3:0] dv;
  logic [7:0] dd [4];
  logic       rdy0, rdy1, rdy2, rdy3;
  logic       tx0, tx1, tx2, tx3;
  logic       bz0, bz1, bz2, bz3;
  logic [3:0] rdy, txv, bsy;

  assign rdy = {rdy3, rdy2, rdy1, rdy0};
  assign txv = {tx3, tx2, tx1, tx0};
  assign bsy = {bz3, bz2, bz1, bz0};

  stream_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(dv[0]), .in_data(dd[0]),
    .in_ready(rdy0), .tx(tx0), .busy(bz0));
  stream_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(dv[1]), .in_data(dd[1]),
    .in_ready(rdy1), .tx(tx1), .busy(bz1));
  stream_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) u_dut2 (
    .clk(clk), .reset(reset), .in_valid(dv[2]), .in_data(dd[2]),
    .in_ready(rdy2), .tx(tx2), .busy(bz2));
  stream_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(1), .PARITY(0), .STOP_BITS(2)) u_dut3 (
    .clk(clk), .reset(reset), .in_valid(dv[3]), .in_data(dd[3]),
    .in_ready(rdy3), .tx(tx3), .busy(bz3));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int         k;
    logic [7:0] d;
    bit         hold;
    int         len;
  } vec_t;
  vec_t tbl [8];

  logic [7:0] words [3];
  int         hs_at [3];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  function automatic int cpb_of(input int k);
    return (k == 3) ? 1 : 4;
  endfunction

  function automatic int par_of(input int k);
    return (k == 1) ? 1 : (k == 2) ? 2 : 0;
  endfunction

  function automatic int stop_of(input int k);
    return (k == 3) ? 2 : 1;
  endfunction

  function automatic int model_len(input int k);
    return (1 + 8 + ((par_of(k) != 0) ? 1 : 0) + stop_of(k)) * cpb_of(k);
  endfunction

  // Expected line level at cycle i after the accepting edge, from the bit position alone.
  function automatic logic exp_tx(input int k, input logic [7:0] d, input int i);
    int pos;
    pos = i / cpb_of(k);
    if (pos == 0) return 1'b0;
    if (pos <= 8) return d[3'(pos - 1)];
    if (par_of(k) != 0 && pos == 9) return (par_of(k) == 1) ? (^d) : (~^d);
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Entered and left at a negedge; sends one word and checks every cycle of the frame.
  task automatic run_frame(input int k, input logic [7:0] d, input bit hold, input int len);
    int t;
    t = 0;
    while (!rdy[k] && t < 200) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("ready_before k%0d", k), 32'(rdy[k]), 32'd1);
    dv[k] = 1'b1;
    dd[k] = d;
    @(posedge clk);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      check($sformatf("tx k%0d d%02h c%0d", k, d, i), 32'(txv[k]), 32'(exp_tx(k, d, i)));
      check($sformatf("busy k%0d d%02h c%0d", k, d, i), 32'(bsy[k]), 32'd1);
      check($sformatf("ready k%0d d%02h c%0d", k, d, i), 32'(rdy[k]), 32'(i == len - 1));
      dd[k] = 8'($urandom);
      dv[k] = hold && (i != len - 1);
    end
    @(negedge clk);
    check($sformatf("idle_tx k%0d", k), 32'(txv[k]), 32'd1);
    check($sformatf("idle_busy k%0d", k), 32'(bsy[k]), 32'd0);
  endtask

  initial begin
    int idx;
    int hs;
    bit pend;

    reset = 1'b1;
    dv    = '0;
    for (int k = 0; k < 4; k++) dd[k] = '0;

    tbl[0] = '{k: 0, d: 8'hA5, hold: 1'b0, len: 40};
    tbl[1] = '{k: 1, d: 8'h07, hold: 1'b0, len: 44};
    tbl[2] = '{k: 2, d: 8'h07, hold: 1'b0, len: 44};
    tbl[3] = '{k: 3, d: 8'h3C, hold: 1'b0, len: 11};
    tbl[4] = '{k: 0, d: 8'h5A, hold: 1'b1, len: 40};
    tbl[5] = '{k: 1, d: 8'hFF, hold: 1'b1, len: 44};
    tbl[6] = '{k: 2, d: 8'h00, hold: 1'b0, len: 44};
    tbl[7] = '{k: 3, d: 8'hC3, hold: 1'b1, len: 11};

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("reset_tx k%0d", k), 32'(txv[k]), 32'd1);
      check($sformatf("reset_busy k%0d", k), 32'(bsy[k]), 32'd0);
    end
    reset = 1'b0;

    // Idle with no valid: line stays high, nothing starts.
    repeat (10) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        check($sformatf("idle_tx k%0d", k), 32'(txv[k]), 32'd1);
        check($sformatf("idle_busy k%0d", k), 32'(bsy[k]), 32'd0);
        check($sformatf("idle_ready k%0d", k), 32'(rdy[k]), 32'd1);
      end
    end

    for (int v = 0; v < 8; v++) begin
      run_frame(tbl[v].k, tbl[v].d, tbl[v].hold, tbl[v].len);
    end

    // Three words with valid held high: gapless frames, handshakes 40 cycles apart.
    words[0] = 8'h01;
    words[1] = 8'h80;
    words[2] = 8'hFF;
    idx  = 0;
    hs   = 0;
    pend = 1'b0;
    dv[0] = 1'b1;
    dd[0] = words[0];
    if (dv[0] && rdy[0]) begin
      hs_at[0] = -1;
      hs = 1;
      pend = 1'b1;
    end
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      check($sformatf("b2b_tx c%0d", i), 32'(txv[0]), 32'(exp_tx(0, words[i / 40], i % 40)));
      check($sformatf("b2b_busy c%0d", i), 32'(bsy[0]), 32'd1);
      if (pend) begin
        idx++;
        if (idx < 3) dd[0] = words[idx];
        else dv[0] = 1'b0;
        pend = 1'b0;
      end
      if (dv[0] && rdy[0]) begin
        if (hs < 3) hs_at[hs] = i;
        hs++;
        pend = 1'b1;
      end
    end
    check("b2b_handshakes", 32'(hs), 32'd3);
    check("b2b_hs1_cycle", 32'(hs_at[1]), 32'd39);
    check("b2b_hs2_cycle", 32'(hs_at[2]), 32'd79);
    @(negedge clk);
    check("b2b_end_tx", 32'(txv[0]), 32'd1);
    check("b2b_end_busy", 32'(bsy[0]), 32'd0);

    // Reset in the 17th cycle of a frame drops the word; the next one goes out intact.
    @(negedge clk);
    dv[0] = 1'b1;
    dd[0] = 8'h96;
    @(posedge clk);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      dv[0] = 1'b0;
    end
    check("pre_reset_tx", 32'(txv[0]), 32'(exp_tx(0, 8'h96, 16)));
    check("pre_reset_busy", 32'(bsy[0]), 32'd1);
    reset = 1'b1;
    #1;
    check("async_reset_tx", 32'(txv[0]), 32'd1);
    check("async_reset_busy", 32'(bsy[0]), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_reset_ready", 32'(rdy[0]), 32'd1);
    repeat (3) begin
      @(negedge clk);
      check("post_reset_tx", 32'(txv[0]), 32'd1);
      check("post_reset_busy", 32'(bsy[0]), 32'd0);
    end
    run_frame(0, 8'h69, 1'b0, 40);

    // Random words on random configurations, with random idle gaps.
    for (int r = 0; r < 30; r++) begin
      int         k;
      logic [7:0] d;
      bit         hold;
      k    = int'($urandom_range(0, 3));
      d    = 8'($urandom);
      hold = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_frame(k, d, hold, model_len(k));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
